// File: rtl/mem_cmd_arbiter.sv
// mem_cmd_arbiter
// Shares the single MemoryControl command port between InOutControl (port 0) and a
// secondary engine (port 1). Round-robin arbitration, one command in flight, busy/done
// sequencing towards memory, level done handshake per requester and a command timeout.
module mem_cmd_arbiter #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req0_cmd,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic [DATA_W-1:0] req0_rdata,
  output logic              req0_done,
  input  logic [1:0]        req1_cmd,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              req1_done,
  output logic [1:0]        mem_cmd,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_done,
  output logic [1:0]        grant,
  output logic              timeout_err
);

  localparam int               CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       CMD_NONE = 2'b00;
  localparam logic [1:0]       CMD_READ = 2'b01;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_BUSY = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } arbState_e;

  arbState_e         state, stateNext;
  logic              lastPort, lastPortNext;   // port granted most recently
  logic              owner, ownerNext;         // port owning the in-flight command
  logic [1:0]        capCmd, capCmdNext;       // captured command, decides rdata update
  logic [1:0]        memCmdR, memCmdNext;
  logic [ADDR_W-1:0] memAddrR, memAddrNext;
  logic [DATA_W-1:0] memWdataR, memWdataNext;
  logic [1:0]        grantR, grantNext;
  logic [DATA_W-1:0] rdata0R, rdata0Next;
  logic [DATA_W-1:0] rdata1R, rdata1Next;
  logic              done0R, done0Next;
  logic              done1R, done1Next;
  logic [CNT_W-1:0]  tmoCnt, tmoCntNext;
  logic              tmoErrR, tmoErrNext;

  logic              req0Act;
  logic              req1Act;
  logic              winner;
  logic              tmoHit;
  logic [1:0]        ownerCmd;

  assign req0Act  = (req0_cmd != CMD_NONE);
  assign req1Act  = (req1_cmd != CMD_NONE);
  // On a tie the port not granted last wins; otherwise the only requester wins.
  assign winner   = (req0Act && req1Act) ? ~lastPort : req1Act;
  assign ownerCmd = owner ? req1_cmd : req0_cmd;
  assign tmoHit   = (tmoCnt == TMO_LAST);

  // Next-state and next-output logic for the arbitration/sequencing FSM.
  always_comb begin
    stateNext    = state;
    lastPortNext = lastPort;
    ownerNext    = owner;
    capCmdNext   = capCmd;
    memCmdNext   = memCmdR;
    memAddrNext  = memAddrR;
    memWdataNext = memWdataR;
    grantNext    = grantR;
    rdata0Next   = rdata0R;
    rdata1Next   = rdata1R;
    done0Next    = done0R;
    done1Next    = done1R;
    tmoCntNext   = tmoCnt;
    tmoErrNext   = tmoErrR;

    case (state)
      IDLE: begin
        if (mem_done && (req0Act || req1Act)) begin
          ownerNext    = winner;
          lastPortNext = winner;
          capCmdNext   = winner ? req1_cmd   : req0_cmd;
          memCmdNext   = winner ? req1_cmd   : req0_cmd;
          memAddrNext  = winner ? req1_addr  : req0_addr;
          memWdataNext = winner ? req1_wdata : req0_wdata;
          grantNext    = winner ? 2'b10 : 2'b01;
          tmoCntNext   = '0;
          stateNext    = WAIT_BUSY;
        end else begin
          stateNext    = IDLE;
        end
      end

      WAIT_BUSY, WAIT_DONE: begin
        if ((state == WAIT_DONE) && mem_done) begin
          // Completion: release the memory port and report to the owner.
          memCmdNext = CMD_NONE;
          stateNext  = RELEASE;
          if (owner) begin
            done1Next = 1'b1;
            if (capCmd == CMD_READ) begin
              rdata1Next = mem_rdata;
            end else begin
              rdata1Next = rdata1R;
            end
          end else begin
            done0Next = 1'b1;
            if (capCmd == CMD_READ) begin
              rdata0Next = mem_rdata;
            end else begin
              rdata0Next = rdata0R;
            end
          end
        end else if (tmoHit) begin
          // Abort: all-ones data signals the failure to the owner, even for writes.
          memCmdNext = CMD_NONE;
          tmoErrNext = 1'b1;
          tmoCntNext = tmoCnt + CNT_ONE;
          stateNext  = RELEASE;
          if (owner) begin
            done1Next  = 1'b1;
            rdata1Next = {DATA_W{1'b1}};
          end else begin
            done0Next  = 1'b1;
            rdata0Next = {DATA_W{1'b1}};
          end
        end else begin
          tmoCntNext = tmoCnt + CNT_ONE;
          if ((state == WAIT_BUSY) && !mem_done) begin
            stateNext = WAIT_DONE;
          end else begin
            stateNext = state;
          end
        end
      end

      RELEASE: begin
        // Done stays high until the owner withdraws its command.
        if (ownerCmd == CMD_NONE) begin
          grantNext = 2'b00;
          stateNext = IDLE;
          if (owner) begin
            done1Next = 1'b0;
          end else begin
            done0Next = 1'b0;
          end
        end else begin
          stateNext = RELEASE;
        end
      end

      default: begin
        stateNext  = IDLE;
        memCmdNext = CMD_NONE;
        grantNext  = 2'b00;
      end
    endcase
  end

  // State and output registers; reset returns to idle with port 0 favoured.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      lastPort  <= 1'b1;
      owner     <= 1'b0;
      capCmd    <= 2'b00;
      memCmdR   <= 2'b00;
      memAddrR  <= '0;
      memWdataR <= '0;
      grantR    <= 2'b00;
      rdata0R   <= '0;
      rdata1R   <= '0;
      done0R    <= 1'b0;
      done1R    <= 1'b0;
      tmoCnt    <= '0;
      tmoErrR   <= 1'b0;
    end else begin
      state     <= stateNext;
      lastPort  <= lastPortNext;
      owner     <= ownerNext;
      capCmd    <= capCmdNext;
      memCmdR   <= memCmdNext;
      memAddrR  <= memAddrNext;
      memWdataR <= memWdataNext;
      grantR    <= grantNext;
      rdata0R   <= rdata0Next;
      rdata1R   <= rdata1Next;
      done0R    <= done0Next;
      done1R    <= done1Next;
      tmoCnt    <= tmoCntNext;
      tmoErrR   <= tmoErrNext;
    end
  end

  assign mem_cmd     = memCmdR;
  assign mem_addr    = memAddrR;
  assign mem_wdata   = memWdataR;
  assign grant       = grantR;
  assign req0_rdata  = rdata0R;
  assign req1_rdata  = rdata1R;
  assign req0_done   = done0R;
  assign req1_done   = done1R;
  assign timeout_err = tmoErrR;

endmodule

// File: tb/tb_mem_cmd_arbiter.sv
// Bench for mem_cmd_arbiter: directed stimulus, a MemoryControl responder model and a
// scoreboard monitor that checks every command issue and every done rise.
module tb_mem_cmd_arbiter;

  localparam int ADDR_W  = 64;
  localparam int DATA_W  = 32;
  localparam int TIMEOUT = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [1:0]        req0_cmd = 2'b00;
  logic [ADDR_W-1:0] req0_addr = '0;
  logic [DATA_W-1:0] req0_wdata = '0;
  logic [DATA_W-1:0] req0_rdata;
  logic              req0_done;
  logic [1:0]        req1_cmd = 2'b00;
  logic [ADDR_W-1:0] req1_addr = '0;
  logic [DATA_W-1:0] req1_wdata = '0;
  logic [DATA_W-1:0] req1_rdata;
  logic              req1_done;
  logic [1:0]        mem_cmd;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_done = 1'b1;
  logic [1:0]        grant;
  logic              timeout_err;

  mem_cmd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .req0_cmd(req0_cmd), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req0_rdata(req0_rdata), .req0_done(req0_done),
    .req1_cmd(req1_cmd), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .req1_rdata(req1_rdata), .req1_done(req1_done),
    .mem_cmd(mem_cmd), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_done(mem_done),
    .grant(grant), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]        grant;
    logic [1:0]        cmd;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } issue_t;

  typedef struct {
    logic              port;
    logic [DATA_W-1:0] rdata;
    logic              terr;
  } done_t;

  issue_t issueQ[$];
  done_t  doneQ[$];

  // Memory model controls
  int                busyCycles = 2;
  bit                stall = 1'b0;
  bit                holdLow = 1'b0;
  logic [DATA_W-1:0] respData = '0;
  bit                memBusy = 1'b0;
  int                busyCnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expectIssue(input logic port, input logic [1:0] cmd,
                             input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wdata);
    issue_t e;
    e.grant = port ? 2'b10 : 2'b01;
    e.cmd   = cmd;
    e.addr  = addr;
    e.wdata = wdata;
    issueQ.push_back(e);
  endtask

  task automatic expectDone(input logic port, input logic [DATA_W-1:0] rdata, input logic terr);
    done_t e;
    e.port  = port;
    e.rdata = rdata;
    e.terr  = terr;
    doneQ.push_back(e);
  endtask

  task automatic waitDone(input logic port, input int budget, output int cycles);
    bit got;
    got = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if ((port ? req1_done : req0_done) == 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL wait_done_port%0d: no done within %0d cycles", port, budget);
    end
  endtask

  // MemoryControl responder: drops mem_done for busyCycles after a command appears.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        mem_done = 1'b1;
        memBusy  = 1'b0;
        busyCnt  = 0;
      end else if (memBusy) begin
        if (!stall) begin
          if (busyCnt > 1) begin
            busyCnt--;
          end else begin
            mem_done = 1'b1;
            memBusy  = 1'b0;
          end
        end
      end else if (holdLow) begin
        mem_done = 1'b0;
      end else if (mem_cmd != 2'b00) begin
        mem_done  = 1'b0;
        memBusy   = 1'b1;
        busyCnt   = busyCycles;
        mem_rdata = respData;
      end else begin
        mem_done = 1'b1;
      end
    end
  end

  // Scoreboard monitor: compares each issue and each done rise with the queued expectation.
  initial begin
    logic [1:0] prevCmd;
    logic       prevD0;
    logic       prevD1;
    issue_t     ei;
    done_t      ed;
    prevCmd = 2'b00;
    prevD0  = 1'b0;
    prevD1  = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_cmd != 2'b00 && prevCmd == 2'b00) begin
        if (issueQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_issue: got cmd %0h grant %0h expected no issue", mem_cmd, grant);
        end else begin
          ei = issueQ.pop_front();
          check("issue_grant", 64'(grant), 64'(ei.grant));
          check("issue_cmd", 64'(mem_cmd), 64'(ei.cmd));
          check("issue_addr", mem_addr, ei.addr);
          check("issue_wdata", 64'(mem_wdata), 64'(ei.wdata));
        end
      end
      if ((req0_done && !prevD0) || (req1_done && !prevD1)) begin
        if (doneQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done0 %0b done1 %0b expected none", req0_done, req1_done);
        end else begin
          ed = doneQ.pop_front();
          check("done_port", 64'(req1_done && !prevD1), 64'(ed.port));
          check("done_rdata", 64'(ed.port ? req1_rdata : req0_rdata), 64'(ed.rdata));
          check("done_terr", 64'(timeout_err), 64'(ed.terr));
        end
      end
      prevCmd = mem_cmd;
      prevD0  = req0_done;
      prevD1  = req1_done;
    end
  end

  // Directed stimulus
  initial begin
    int cyc;
    int r0Left;
    int r1Left;
    bit fin;

    // Reset: two cycles of rst, every output at zero.
    repeat (2) @(negedge clk);
    check("rst_mem_cmd", 64'(mem_cmd), 64'h0);
    check("rst_grant", 64'(grant), 64'h0);
    check("rst_mem_addr", mem_addr, 64'h0);
    check("rst_mem_wdata", 64'(mem_wdata), 64'h0);
    check("rst_done0", 64'(req0_done), 64'h0);
    check("rst_done1", 64'(req1_done), 64'h0);
    check("rst_rdata0", 64'(req0_rdata), 64'h0);
    check("rst_rdata1", 64'(req1_rdata), 64'h0);
    check("rst_terr", 64'(timeout_err), 64'h0);
    rst = 1'b0;

    // Single read on port 0.
    respData = 32'hCAFE0001;
    busyCycles = 2;
    req0_cmd = 2'b01; req0_addr = 64'h10; req0_wdata = 32'h0;
    expectIssue(1'b0, 2'b01, 64'h10, 32'h0);
    expectDone(1'b0, 32'hCAFE0001, 1'b0);
    @(negedge clk);
    check("read_issue_latency", 64'(mem_cmd), 64'h1);
    waitDone(1'b0, 20, cyc);
    check("read_done_latency", 64'(cyc), 64'd3);
    check("read_rdata", 64'(req0_rdata), 64'hCAFE0001);
    req0_cmd = 2'b00;
    @(negedge clk);
    check("read_done_clear", 64'(req0_done), 64'h0);
    check("read_grant_clear", 64'(grant), 64'h0);
    check("read_rdata_hold", 64'(req0_rdata), 64'hCAFE0001);

    // Fresh reset, then contention with immediate re-requests: 01,10,01,10.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    req0_addr = 64'h20; req0_wdata = 32'hAAAA0000;
    req1_addr = 64'h30; req1_wdata = 32'hBBBB1111;
    req0_cmd = 2'b10; req1_cmd = 2'b10;
    for (int k = 0; k < 2; k++) begin
      expectIssue(1'b0, 2'b10, 64'h20, 32'hAAAA0000);
      expectDone(1'b0, 32'h0, 1'b0);
      expectIssue(1'b1, 2'b10, 64'h30, 32'hBBBB1111);
      expectDone(1'b1, 32'h0, 1'b0);
    end
    r0Left = 1; r1Left = 1; fin = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (req0_done && req0_cmd != 2'b00) req0_cmd = 2'b00;
      else if (!req0_done && req0_cmd == 2'b00 && r0Left > 0) begin req0_cmd = 2'b10; r0Left--; end
      if (req1_done && req1_cmd != 2'b00) req1_cmd = 2'b00;
      else if (!req1_done && req1_cmd == 2'b00 && r1Left > 0) begin req1_cmd = 2'b10; r1Left--; end
      if (r0Left == 0 && r1Left == 0 && req0_cmd == 2'b00 && req1_cmd == 2'b00 &&
          !req0_done && !req1_done) begin
        fin = 1'b1;
        break;
      end
    end
    check("contention_finished", 64'(fin), 64'h1);

    // Held done on port 1: no new command, grant kept.
    req1_cmd = 2'b10; req1_addr = 64'h60; req1_wdata = 32'h33330000;
    expectIssue(1'b1, 2'b10, 64'h60, 32'h33330000);
    expectDone(1'b1, 32'h0, 1'b0);
    waitDone(1'b1, 20, cyc);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("held_done1", 64'(req1_done), 64'h1);
      check("held_mem_cmd", 64'(mem_cmd), 64'h0);
      check("held_grant", 64'(grant), 64'h2);
    end
    req1_cmd = 2'b00;
    @(negedge clk);
    check("held_release_done", 64'(req1_done), 64'h0);
    check("held_release_grant", 64'(grant), 64'h0);

    // Opaque command 11: sequenced like a write, rdata untouched.
    respData = 32'hDEADBEEF;
    req0_cmd = 2'b11; req0_addr = 64'h70; req0_wdata = 32'h44440000;
    expectIssue(1'b0, 2'b11, 64'h70, 32'h44440000);
    expectDone(1'b0, 32'h0, 1'b0);
    waitDone(1'b0, 20, cyc);
    req0_cmd = 2'b00;
    @(negedge clk);

    // Timeout: memory never completes.
    stall = 1'b1;
    req0_cmd = 2'b01; req0_addr = 64'h80; req0_wdata = 32'h0;
    expectIssue(1'b0, 2'b01, 64'h80, 32'h0);
    expectDone(1'b0, 32'hFFFFFFFF, 1'b1);
    @(negedge clk);
    check("tmo_err_before", 64'(timeout_err), 64'h0);
    waitDone(1'b0, 30, cyc);
    check("tmo_latency", 64'(cyc), 64'd8);
    check("tmo_mem_cmd", 64'(mem_cmd), 64'h0);
    check("tmo_err_set", 64'(timeout_err), 64'h1);
    check("tmo_rdata", 64'(req0_rdata), 64'hFFFFFFFF);
    check("tmo_other_rdata_hold", 64'(req1_rdata), 64'h0);
    req0_cmd = 2'b00;
    stall = 1'b0;
    repeat (5) @(negedge clk);
    check("tmo_err_sticky", 64'(timeout_err), 64'h1);

    // mem_done low in IDLE: request waits, then is served.
    holdLow = 1'b1;
    repeat (2) @(negedge clk);
    respData = 32'h12345678;
    req1_cmd = 2'b01; req1_addr = 64'h90; req1_wdata = 32'h0;
    expectIssue(1'b1, 2'b01, 64'h90, 32'h0);
    expectDone(1'b1, 32'h12345678, 1'b1);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("busy_idle_no_cmd", 64'(mem_cmd), 64'h0);
      check("busy_idle_no_grant", 64'(grant), 64'h0);
    end
    holdLow = 1'b0;
    waitDone(1'b1, 20, cyc);
    check("busy_idle_rdata", 64'(req1_rdata), 64'h12345678);
    req1_cmd = 2'b00;
    @(negedge clk);

    // Reset in WAIT_DONE, then a fresh read on port 1.
    busyCycles = 4;
    respData = 32'h55555555;
    req0_cmd = 2'b01; req0_addr = 64'hA0; req0_wdata = 32'h0;
    expectIssue(1'b0, 2'b01, 64'hA0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    req0_cmd = 2'b00;
    @(negedge clk);
    check("midrst_mem_cmd", 64'(mem_cmd), 64'h0);
    check("midrst_grant", 64'(grant), 64'h0);
    check("midrst_done0", 64'(req0_done), 64'h0);
    check("midrst_terr", 64'(timeout_err), 64'h0);
    @(negedge clk);
    rst = 1'b0;
    busyCycles = 2;
    respData = 32'h0BADF00D;
    req1_cmd = 2'b01; req1_addr = 64'hB0; req1_wdata = 32'h66660000;
    expectIssue(1'b1, 2'b01, 64'hB0, 32'h66660000);
    expectDone(1'b1, 32'h0BADF00D, 1'b0);
    waitDone(1'b1, 20, cyc);
    check("fresh_read_latency", 64'(cyc), 64'd4);
    req1_cmd = 2'b00;
    repeat (3) @(negedge clk);

    check("issueQ_empty", 64'(issueQ.size()), 64'h0);
    check("doneQ_empty", 64'(doneQ.size()), 64'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
